ssd_reader: RTL
===============

# ssd_reader

Receiver for a time-multiplexed two-digit seven-segment display bus: samples segment and digit-select lines, requires each digit pattern to be stable, decodes patterns back to decimal digits and delivers the two-digit value (0..99) through a valid/ready handshake. It is the inverse of the team's binary-to-two-digit seven-segment decoder. It lets test fixtures and loopback paths read back what a display driver is showing.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted; legal range 2..15.
- Clock  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- SegIn  input  7  segment lines, active-low, bit6=g … bit0=a.
- DigitSel  input  2  one-hot digit select: 2'b10 = tens (Dezena), 2'b01 = units (Unidade).
- OutValue  output  7  decoded value, tens*10 + units.
- OutValid  output  1  OutValue holds an unconsumed result.
- OutReady  input  1  consumer accepts OutValue.
- OutError  output  1  one-cycle pulse: accepted pattern was not a legal digit.

## Operation
- Legal patterns (SegIn, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000. The tens position additionally accepts blank 1111111 as 0. Any other pattern is illegal.
- Stability filter: {DigitSel, SegIn} is compared with its previous-cycle value. The run counter reloads to 1 on a change and increments on a match, saturating at STABLE_CYCLES. The acceptance strobe fires on the edge where the counter reaches STABLE_CYCLES. It fires once per run and never refires while the input is unchanged.
- DigitSel 2'b00 or 2'b11 is not a digit: it forces the counter to 0, so no acceptance occurs.
- FSM states:
  - WAIT_TENS: a tens acceptance with a legal pattern latches the tens digit and moves to WAIT_UNITS. A units acceptance is ignored.
  - WAIT_UNITS: a units acceptance with a legal pattern loads OutValue = tens*10 + units, sets OutValid and moves to PRESENT. A tens acceptance replaces the latched tens digit and stays in WAIT_UNITS.
  - PRESENT: OutValid and OutValue are held stable. All acceptances are dropped, with no error. On the edge where OutValid && OutReady, clear OutValid and go to WAIT_TENS.
- Illegal pattern accepted in WAIT_TENS or WAIT_UNITS: OutError pulses for one cycle, the latched tens digit is discarded, and the FSM goes to WAIT_TENS.
- Illegal pattern accepted in PRESENT: dropped silently. OutError stays 0.
- Arithmetic: digits are 4-bit, the product is computed as (tens<<3)+(tens<<1), and the sum fits in 7 bits (max 99).

## Timing
- Reset (synchronous) values: OutValue=0, OutValid=0, OutError=0, FSM=WAIT_TENS, run counter=0, previous-sample register=0.
- Reset asserted mid-operation discards any partial digit and any pending result on that edge.
- Acceptance happens on the edge of the STABLE_CYCLES-th consecutive identical sample. OutValid/OutError are registered and visible after that edge. No combinational path exists from inputs to outputs.
- OutValid, once high, stays high with OutValue constant until the handshake edge.
- A units acceptance coinciding with the handshake edge is dropped, because the FSM is in PRESENT.
- OutError is high for exactly one cycle per illegal acceptance.
- Throughput: at most one result per tens+units pair, i.e. at least 2*STABLE_CYCLES cycles apart.

## Structure
- Shared package `ssd_pkg`, holding:
  - the ten digit segment constants and SEG_BLANK;
  - the FSM state typedef (WAIT_TENS, WAIT_UNITS, PRESENT);
  - the DigitSel encodings SEL_TENS and SEL_UNITS.
- Sub-module `ssd_pattern_decode`: combinational, 7-bit active-low pattern in; 4-bit digit, legal flag and blank flag out. It is instantiated once.
- The top level contains the stability filter, the FSM and the output registers.

## Test plan
- STABLE_CYCLES=4; hold tens=0100100 (2) for 4 cycles, then units=0010010 (5) for 4 cycles -> OutValid rises after the 8th edge with OutValue=25; OutReady=1 -> OutValid low the next cycle.
- Tens blank 1111111 for 4 cycles, units 1111000 for 4 cycles -> OutValue=7.
- Tens 9 held 3 cycles, DigitSel=00 for 1 cycle, tens 9 held 3 cycles -> no acceptance; FSM stays WAIT_TENS and OutValid stays 0.
- Tens 3 accepted, then units 1111111 held 4 cycles -> OutError is a single-cycle pulse, then a fresh tens 1 / units 0 sequence -> OutValue=10, showing the tens 3 was discarded.
- Result 99 pending with OutReady=0; present tens 4 / units 2 -> OutValue stays 99 and OutError stays 0. After the handshake, a new pair is required.
- Assert Reset while in WAIT_UNITS and while in PRESENT -> all outputs 0 the next cycle; a subsequent tens 6 / units 8 sequence -> 68.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment bus reader.
// Holds the active-low segment patterns for each decimal digit and for a
// blank position, the digit-select encodings and the reader FSM state type.
package ssd_pkg;

   // Active-low segment patterns, bit6=g ... bit0=a
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0011000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] SEL_TENS  = 2'b10;
   localparam logic [1:0] SEL_UNITS = 2'b01;

   typedef enum logic [1:0] {
      WAIT_TENS  = 2'd0,
      WAIT_UNITS = 2'd1,
      PRESENT    = 2'd2
   } state_t;

endpackage

// File: rtl/ssd_reader_if.sv
// Bus bundle between a seven-segment display source and the reader.
//   seg_in    : active-low segment lines (bit6=g ... bit0=a)
//   digit_sel : one-hot digit select (10 = tens, 01 = units)
//   out_value : decoded two-digit value 0..99
//   out_valid : out_value holds an unconsumed result
//   out_ready : consumer accepts out_value
//   out_error : one-cycle pulse on an accepted illegal pattern
// master = display source / consumer side, slave = reader.
interface ssd_reader_if;
   logic [6:0] seg_in;
   logic [1:0] digit_sel;
   logic [6:0] out_value;
   logic       out_valid;
   logic       out_ready;
   logic       out_error;

   modport master (
      output seg_in, digit_sel, out_ready,
      input  out_value, out_valid, out_error
   );

   modport slave (
      input  seg_in, digit_sel, out_ready,
      output out_value, out_valid, out_error
   );
endinterface

// File: rtl/ssd_pattern_decode.sv
// Combinational decode of one active-low seven-segment pattern.
//   seg   : 7-bit active-low pattern
//   digit : decoded digit 0..9 (0 for blank or illegal patterns)
//   legal : pattern is one of the ten digit shapes
//   blank : pattern is all segments off
module ssd_pattern_decode
   import ssd_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       legal,
   output logic       blank
);

   always_comb begin
      digit = 4'd0;
      legal = 1'b1;
      blank = 1'b0;
      case (seg)
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         SEG_BLANK: begin
            legal = 1'b0;
            blank = 1'b1;
         end
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/ssd_reader.sv
// Reader for a time-multiplexed two-digit seven-segment display bus.
// Filters each digit for stability, decodes it and presents tens*10+units
// through a valid/ready handshake.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : ssd_reader_if slave (segment/select inputs, result handshake)
//
// state      | meaning
// -----------+-------------------------------------------------
// WAIT_TENS  | no tens digit held, waiting for a tens acceptance
// WAIT_UNITS | tens digit latched, waiting for a units acceptance
// PRESENT    | result valid, waiting for the consumer handshake
module ssd_reader
   import ssd_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   ssd_reader_if.slave  bus
);

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   state_t     state;
   logic [8:0] sample;
   logic [8:0] prev_sample;
   logic [3:0] run_cnt;
   logic [3:0] run_next;
   logic       sel_ok;
   logic       is_tens;
   logic       accept;
   logic [3:0] digit;
   logic       legal;
   logic       blank;
   logic       pat_ok;
   logic [3:0] tens_q;
   logic [6:0] tens_w;
   logic [6:0] sum;
   logic [6:0] value_q;
   logic       valid_q;
   logic       error_q;

   ssd_pattern_decode u_decode (
      .seg   (bus.seg_in),
      .digit (digit),
      .legal (legal),
      .blank (blank)
   );

   assign sample  = {bus.digit_sel, bus.seg_in};
   assign sel_ok  = (bus.digit_sel == SEL_TENS) || (bus.digit_sel == SEL_UNITS);
   assign is_tens = (bus.digit_sel == SEL_TENS);
   // Blank is only a valid shape in the tens position, where it reads as 0
   assign pat_ok  = legal || (blank && is_tens);

   always_comb begin
      run_next = 4'd0;
      if (sel_ok) begin
         if (sample != prev_sample)
            run_next = 4'd1;
         else if (run_cnt < STABLE)
            run_next = run_cnt + 4'd1;
         else
            run_next = run_cnt;
      end
   end

   // Strobe only on the edge the count arrives at STABLE, so a held
   // pattern is accepted once and never again while it stays unchanged.
   assign accept = (run_next == STABLE) && (run_cnt != STABLE);

   assign tens_w = {3'b000, tens_q};
   assign sum    = (tens_w << 3) + (tens_w << 1) + {3'b000, digit};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= WAIT_TENS;
         prev_sample <= '0;
         run_cnt     <= '0;
         tens_q      <= '0;
         value_q     <= '0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         prev_sample <= sample;
         run_cnt     <= run_next;
         error_q     <= 1'b0;
         case (state)
            WAIT_TENS: begin
               if (accept) begin
                  if (!pat_ok) begin
                     error_q <= 1'b1;
                     tens_q  <= '0;
                  end else if (is_tens) begin
                     tens_q <= digit;
                     state  <= WAIT_UNITS;
                  end
               end
            end
            WAIT_UNITS: begin
               if (accept) begin
                  if (!pat_ok) begin
                     error_q <= 1'b1;
                     tens_q  <= '0;
                     state   <= WAIT_TENS;
                  end else if (is_tens) begin
                     tens_q <= digit;
                  end else begin
                     value_q <= sum;
                     valid_q <= 1'b1;
                     state   <= PRESENT;
                  end
               end
            end
            PRESENT: begin
               if (valid_q && bus.out_ready) begin
                  valid_q <= 1'b0;
                  state   <= WAIT_TENS;
               end
            end
            default: state <= WAIT_TENS;
         endcase
      end
   end

   assign bus.out_value = value_q;
   assign bus.out_valid = valid_q;
   assign bus.out_error = error_q;

endmodule
